pc_sequencer: RTL and testbench



---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_sequencer_ras_stack.sv | 85 ++++++++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer:
//   next_src_e     - which source supplies the next PC value
//   PC_DEFAULT_STEP- default sequential increment in bytes
//   step_shift()   - log2 of the (power-of-two) step; this is the number of
//                    low PC bits that must be zero for an aligned target
// -----------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_SEQ    = 3'd0,
      SRC_BRANCH = 3'd1,
      SRC_JUMP   = 3'd2,
      SRC_JREG   = 3'd3,
      SRC_RET    = 3'd4,
      SRC_HOLD   = 3'd5
   } next_src_e;

   localparam int unsigned PC_DEFAULT_STEP = 4;

   function automatic int unsigned step_shift(input int unsigned step);
      int unsigned s;
      s = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) == step) s = i;
      end
      return s;
   endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and the count saturates at DEPTH. Pop and push in the same
// cycle replace the top entry and leave the count unchanged. A pop on an
// empty stack is ignored.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset, clears all entries and count
//   push_i   - push data_i
//   pop_i    - pop the top entry
//   data_i   - value to push
//   top_o    - current top entry (valid when empty_o is low)
//   count_o  - number of valid entries, 0..DEPTH
//   empty_o  - no valid entries
//   full_o   - DEPTH valid entries
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           top_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // sp_q is the next write slot; the top entry lives one below it. Because
   // DEPTH is a power of two the pointer wraps naturally, which is what makes
   // a push onto a full stack land on the oldest entry.
   logic [PTR_W-1:0] sp_q, sp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_idx;
   logic             do_pop;
   logic             do_write;

   assign top_idx = sp_q - PTR_W'(1);
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign count_o = cnt_q;
   assign top_o   = mem_q[top_idx];
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      sp_d     = sp_q;
      cnt_d    = cnt_q;
      wr_idx   = sp_q;
      do_write = 1'b0;
      if (push_i && do_pop) begin
         wr_idx   = top_idx;
         do_write = 1'b1;
      end else if (push_i) begin
         do_write = 1'b1;
         sp_d     = sp_q + PTR_W'(1);
         if (!full_o) cnt_d = cnt_q + CNT_W'(1);
      end else if (do_pop) begin
         sp_d  = top_idx;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         if (do_write) mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Registered program counter for the fetch stage. Each cycle the next PC is
// chosen by priority: Stall (hold), Return, JumpReg, Jump, Branch, sequential.
// Sequential adds STEP; Branch adds STEP plus the sign-extended word offset
// scaled by STEP. Jump targets have their low log2(STEP) bits cleared, and a
// nonzero low part raises a one-cycle Misalign pulse after the load.
//
// Build option PC_SEQ_RAS_EN: when defined, a return-address stack is built;
// Call with a taken Jump/JumpReg pushes PCPlusStep and Return pops into PC.
// When undefined, Call and Return are ignored, RasEmpty=1, RasFull=0,
// Underflow=0.
//
// Ports:
//   Clk, Reset         - clock (rising edge), async active-high reset
//   Stall              - hold PC and stack, suppress error pulses
//   Branch/BranchOffset- taken conditional branch and signed word offset
//   Jump/JumpTarget    - absolute jump
//   JumpReg/RegTarget  - register-indirect jump
//   Call, Return       - stack push qualifier, stack pop
//   PC, PCPlusStep     - registered PC and PC+STEP
//   RasEmpty, RasFull  - stack occupancy flags
//   Underflow          - pulse: Return with an empty stack
//   Misalign           - pulse: jump target had nonzero low bits
// -----------------------------------------------------------------------------
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                 WIDTH        = 32,
   parameter int                 STEP         = PC_DEFAULT_STEP,
   parameter int                 OFFSET_BITS  = 16,
   parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
   parameter int                 RAS_DEPTH    = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Stall,
   input  logic                   Branch,
   input  logic [OFFSET_BITS-1:0] BranchOffset,
   input  logic                   Jump,
   input  logic [WIDTH-1:0]       JumpTarget,
   input  logic                   JumpReg,
   input  logic [WIDTH-1:0]       RegTarget,
   input  logic                   Call,
   input  logic                   Return,
   output logic [WIDTH-1:0]       PC,
   output logic [WIDTH-1:0]       PCPlusStep,
   output logic                   RasEmpty,
   output logic                   RasFull,
   output logic                   Underflow,
   output logic                   Misalign
);

   localparam int               SHIFT    = int'(step_shift(STEP));
   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             underflow_q, underflow_d;
   logic             misalign_q, misalign_d;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] off_ext;
   logic [WIDTH-1:0] branch_tgt;
   next_src_e        src;

   logic             ret_req;
   logic             ras_empty;
   logic [WIDTH-1:0] ras_top;

   assign pc_plus    = pc_q + WIDTH'(STEP);
   assign off_ext    = {{(WIDTH-OFFSET_BITS){BranchOffset[OFFSET_BITS-1]}}, BranchOffset};
   assign branch_tgt = pc_plus + (off_ext << SHIFT);

`ifdef PC_SEQ_RAS_EN
   logic                         ras_push;
   logic                         ras_pop;
   logic                         ras_full;
   logic [$clog2(RAS_DEPTH+1)-1:0] unused_ras_count;

   // The push is gated only by Call and a taken jump: when Return is also
   // present the PC comes from the stack, but the return address still goes
   // in, replacing the popped top.
   assign ras_push = ~Stall & Call & (Jump | JumpReg);
   assign ras_pop  = ~Stall & Return;
   assign ret_req  = Return;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (WIDTH)
   ) u_ras (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (pc_plus),
      .top_o   (ras_top),
      .count_o (unused_ras_count),
      .empty_o (ras_empty),
      .full_o  (ras_full)
   );

   assign RasEmpty  = ras_empty;
   assign RasFull   = ras_full;
   assign Underflow = underflow_q;
`else
   logic unused_ras_inputs;

   assign unused_ras_inputs = ^{Call, Return, underflow_q};
   assign ret_req   = 1'b0;
   assign ras_empty = 1'b1;
   assign ras_top   = '0;
   assign RasEmpty  = 1'b1;
   assign RasFull   = 1'b0;
   assign Underflow = 1'b0;
`endif

   always_comb begin
      src         = SRC_SEQ;
      pc_d        = pc_q;
      underflow_d = 1'b0;
      misalign_d  = 1'b0;

      if (Stall)        src = SRC_HOLD;
      else if (ret_req) src = SRC_RET;
      else if (JumpReg) src = SRC_JREG;
      else if (Jump)    src = SRC_JUMP;
      else if (Branch)  src = SRC_BRANCH;

      case (src)
         SRC_HOLD:   pc_d = pc_q;
         SRC_RET: begin
            if (ras_empty) begin
               pc_d        = pc_plus;
               underflow_d = 1'b1;
            end else begin
               pc_d = ras_top;
            end
         end
         SRC_JREG: begin
            pc_d       = RegTarget & ~LOW_MASK;
            misalign_d = |(RegTarget & LOW_MASK);
         end
         SRC_JUMP: begin
            pc_d       = JumpTarget & ~LOW_MASK;
            misalign_d = |(JumpTarget & LOW_MASK);
         end
         SRC_BRANCH: pc_d = branch_tgt;
         default:    pc_d = pc_plus;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q        <= RESET_VECTOR;
         underflow_q <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         underflow_q <= underflow_d;
         misalign_q  <= misalign_d;
      end
   end

   assign PC         = pc_q;
   assign PCPlusStep = pc_plus;
   assign Misalign   = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        Branch;
   logic [15:0] BranchOffset;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        JumpReg;
   logic [31:0] RegTarget;
   logic        Call;
   logic        Return;
   logic [31:0] PC;
   logic [31:0] PCPlusStep;
   logic        RasEmpty;
   logic        RasFull;
   logic        Underflow;
   logic        Misalign;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer #(
      .WIDTH        (32),
      .STEP         (4),
      .OFFSET_BITS  (16),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (4)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Stall        (Stall),
      .Branch       (Branch),
      .BranchOffset (BranchOffset),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .JumpReg      (JumpReg),
      .RegTarget    (RegTarget),
      .Call         (Call),
      .Return       (Return),
      .PC           (PC),
      .PCPlusStep   (PCPlusStep),
      .RasEmpty     (RasEmpty),
      .RasFull      (RasFull),
      .Underflow    (Underflow),
      .Misalign     (Misalign)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Stall        = 1'b0;
      Branch       = 1'b0;
      BranchOffset = '0;
      Jump         = 1'b0;
      JumpTarget   = '0;
      JumpReg      = 1'b0;
      RegTarget    = '0;
      Call         = 1'b0;
      Return       = 1'b0;
   endtask

   task automatic jump_to(input logic [31:0] t, input logic with_call);
      idle();
      Jump       = 1'b1;
      JumpTarget = t;
      Call       = with_call;
      tick();
   endtask

   initial begin
      idle();
      Reset = 1'b1;
      #3;
      check("rst_pc", PC, 32'h0);
      check("rst_empty", RasEmpty, 1'b1);
      check("rst_full", RasFull, 1'b0);
      check("rst_underflow", Underflow, 1'b0);
      check("rst_misalign", Misalign, 1'b0);
      #4;
      check("rst_hold_pc", PC, 32'h0);
      Reset = 1'b0;
      check("seq_pc0", PC, 32'h0);
      check("seq_plus0", PCPlusStep, 32'h4);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("seq_pc", PC, 32'(4 * i));
         check("seq_plus", PCPlusStep, 32'(4 * i + 4));
      end

      // branch backwards, then stall over a competing jump
      jump_to(32'h100, 1'b0);
      check("jmp_pc", PC, 32'h100);
      check("jmp_aligned_mis", Misalign, 1'b0);
      idle();
      Branch       = 1'b1;
      BranchOffset = 16'hFFFE;
      tick();
      check("br_neg_pc", PC, 32'h0FC);
      idle();
      Stall      = 1'b1;
      Jump       = 1'b1;
      JumpTarget = 32'h500;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", PC, 32'h0FC);
      end

      // JumpReg beats Jump; misaligned target is truncated and flagged
      idle();
      JumpReg    = 1'b1;
      RegTarget  = 32'h203;
      Jump       = 1'b1;
      JumpTarget = 32'h800;
      tick();
      check("jreg_pc", PC, 32'h200);
      check("jreg_mis", Misalign, 1'b1);
      idle();
      tick();
      check("after_jreg_pc", PC, 32'h204);
      check("mis_pulse_end", Misalign, 1'b0);
      idle();
      Stall      = 1'b1;
      Jump       = 1'b1;
      JumpTarget = 32'h3;
      tick();
      check("stall_mis_pc", PC, 32'h204);
      check("stall_mis_flag", Misalign, 1'b0);
      idle();
      Branch       = 1'b1;
      BranchOffset = 16'h0003;
      tick();
      check("br_pos_pc", PC, 32'h214);

      // wrap
      jump_to(32'hFFFF_FFFC, 1'b0);
      check("wrap_pc", PC, 32'hFFFF_FFFC);
      check("wrap_plus", PCPlusStep, 32'h0);
      idle();
      tick();
      check("wrap_seq", PC, 32'h0);

      // five calls into a four-deep stack
      for (int i = 0; i < 5; i++) begin
         jump_to(32'(32'h1000 * (i + 1)), 1'b1);
         check("call_pc", PC, 32'(32'h1000 * (i + 1)));
         check("call_full", RasFull, RAS && (i >= 3));
         check("call_empty", RasEmpty, !RAS);
      end
      for (int i = 0; i < 5; i++) begin
         idle();
         Return = 1'b1;
         tick();
         if (RAS)
            check("ret_pc", PC, (i < 4) ? 32'(32'h4004 - 32'h1000 * i) : 32'h1008);
         else
            check("ret_pc", PC, 32'(32'h5004 + 4 * i));
         check("ret_underflow", Underflow, RAS && (i == 4));
         check("ret_empty", RasEmpty, !RAS || (i >= 3));
         check("ret_full", RasFull, 1'b0);
      end
      idle();
      tick();
      check("uf_pulse_end", Underflow, 1'b0);
      check("after_uf_pc", PC, RAS ? 32'h100C : 32'h5018);

      // Return beats Jump and Branch; Return+Call replaces top
      jump_to(32'h10, 1'b0);
      idle();
      Call      = 1'b1;
      JumpReg   = 1'b1;
      RegTarget = 32'h3C;
      tick();
      check("jreg_call_pc", PC, 32'h3C);
      jump_to(32'h80, 1'b1);
      idle();
      Return       = 1'b1;
      Jump         = 1'b1;
      JumpTarget   = 32'h900;
      Branch       = 1'b1;
      BranchOffset = 16'h0010;
      tick();
      check("ret_prio_pc", PC, RAS ? 32'h40 : 32'h900);
      check("ret_prio_empty", RasEmpty, !RAS);
      idle();
      Return = 1'b1;
      tick();
      check("ret_second_pc", PC, RAS ? 32'h14 : 32'h904);
      check("ret_second_empty", RasEmpty, 1'b1);
      jump_to(32'h60, 1'b1);
      idle();
      Return     = 1'b1;
      Call       = 1'b1;
      Jump       = 1'b1;
      JumpTarget = 32'h70;
      tick();
      check("retcall_pc", PC, RAS ? 32'h18 : 32'h70);
      check("retcall_empty", RasEmpty, !RAS);
      idle();
      Return = 1'b1;
      tick();
      check("retcall_top", PC, RAS ? 32'h64 : 32'h74);
      check("retcall_drained", RasEmpty, 1'b1);

      // asynchronous reset with three entries stacked and a request pending
      jump_to(32'h700, 1'b1);
      jump_to(32'h710, 1'b1);
      jump_to(32'h720, 1'b1);
      check("pre_rst_empty", RasEmpty, !RAS);
      idle();
      Call       = 1'b1;
      Jump       = 1'b1;
      JumpTarget = 32'h900;
      Reset      = 1'b1;
      #2;
      check("async_rst_pc", PC, 32'h0);
      check("async_rst_plus", PCPlusStep, 32'h4);
      check("async_rst_empty", RasEmpty, 1'b1);
      check("async_rst_full", RasFull, 1'b0);
      tick();
      check("rst_held_pc", PC, 32'h0);
      Reset = 1'b0;
      idle();
      Return = 1'b1;
      tick();
      check("post_rst_ret_pc", PC, 32'h4);
      check("post_rst_uf", Underflow, RAS);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
